// File: rtl/id_ex_stage_pkg.sv
// Shared widths, register-index constants and the decoded control bundle layout
// for the ID/EX boundary.
package id_ex_stage_pkg;

    localparam int unsigned DEF_XLEN   = 32;
    localparam int unsigned DEF_CTRL_W = 16;
    localparam int unsigned REG_W      = 5;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // Layout of the control bundle; the ID/EX register carries it opaquely.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic [2:0] funct3;
        logic [1:0] rsvd;
    } ctrl_bundle_t;

    // True when a writeback lands on a nonzero register matching rs_addr.
    function automatic logic wb_hit(input logic             we,
                                    input logic [REG_W-1:0] wb_addr,
                                    input logic [REG_W-1:0] rs_addr);
        return we && (wb_addr != REG_ZERO) && (wb_addr == rs_addr);
    endfunction

endpackage

// File: rtl/id_ex_stage_operand_bypass.sv
// Combinational writeback-to-operand correction; also reused to refresh held EX operands.
module operand_bypass
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN
) (
    input  logic [REG_W-1:0] rs_addr,
    input  logic [XLEN-1:0]  rf_data,
    input  logic             wb_we,
    input  logic [REG_W-1:0] wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  data_out
);

    always_comb begin
        data_out = rf_data;
        if (wb_hit(wb_we, wb_addr, rs_addr)) begin
            data_out = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB write-through bypass, load-use bubble insertion,
// downstream stall hold and branch flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN   = DEF_XLEN,
    parameter int unsigned CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [REG_W-1:0]  id_rs1_addr,
    input  logic [REG_W-1:0]  id_rs2_addr,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [REG_W-1:0]  id_rd_addr,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_mem_read,
    input  logic              wb_RegWEn,
    input  logic [REG_W-1:0]  wb_rd_addr,
    input  logic [XLEN-1:0]   wb_rd_data,
    input  logic              ex_stall,
    input  logic              ex_flush,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [REG_W-1:0]  ex_rs1_addr,
    output logic [REG_W-1:0]  ex_rs2_addr,
    output logic [REG_W-1:0]  ex_rd_addr,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read
);

    logic [XLEN-1:0] byp1;
    logic [XLEN-1:0] byp2;
    logic [XLEN-1:0] hold1;
    logic [XLEN-1:0] hold2;
    logic            hold_we;
    logic            hz;

    operand_bypass #(.XLEN(XLEN)) u_byp_rs1 (
        .rs_addr (id_rs1_addr),
        .rf_data (id_rs1_data),
        .wb_we   (wb_RegWEn),
        .wb_addr (wb_rd_addr),
        .wb_data (wb_rd_data),
        .data_out(byp1)
    );

    operand_bypass #(.XLEN(XLEN)) u_byp_rs2 (
        .rs_addr (id_rs2_addr),
        .rf_data (id_rs2_data),
        .wb_we   (wb_RegWEn),
        .wb_addr (wb_rd_addr),
        .wb_data (wb_rd_data),
        .data_out(byp2)
    );

    // Held operands track writebacks so they are current when the stall releases.
    assign hold_we = ex_valid && wb_RegWEn;

    operand_bypass #(.XLEN(XLEN)) u_hold_rs1 (
        .rs_addr (ex_rs1_addr),
        .rf_data (ex_rs1_data),
        .wb_we   (hold_we),
        .wb_addr (wb_rd_addr),
        .wb_data (wb_rd_data),
        .data_out(hold1)
    );

    operand_bypass #(.XLEN(XLEN)) u_hold_rs2 (
        .rs_addr (ex_rs2_addr),
        .rf_data (ex_rs2_data),
        .wb_we   (hold_we),
        .wb_addr (wb_rd_addr),
        .wb_data (wb_rd_data),
        .data_out(hold2)
    );

    always_comb begin
        hz = ex_valid && ex_mem_read && (ex_rd_addr != REG_ZERO) && id_valid &&
             ((id_use_rs1 && (id_rs1_addr == ex_rd_addr)) ||
              (id_use_rs2 && (id_rs2_addr == ex_rd_addr)));
        stall_id = !ex_flush && (ex_stall || hz);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ex_ctrl     <= '0;
            ex_mem_read <= 1'b0;
        end else if (ex_flush) begin
            ex_valid    <= 1'b0;
            ex_mem_read <= 1'b0;
        end else if (ex_stall) begin
            ex_rs1_data <= hold1;
            ex_rs2_data <= hold2;
        end else if (hz) begin
            ex_valid    <= 1'b0;
            ex_mem_read <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_imm      <= id_imm;
            ex_rs1_data <= byp1;
            ex_rs2_data <= byp2;
            ex_rs1_addr <= id_rs1_addr;
            ex_rs2_addr <= id_rs2_addr;
            ex_rd_addr  <= id_rd_addr;
            ex_ctrl     <= id_ctrl;
            // An empty ID slot must never look like a load downstream.
            ex_mem_read <= id_valid && id_mem_read;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// against a behavioural pipeline-register model.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int unsigned XW = 32;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [XW-1:0] id_pc;
    logic [4:0]    id_rs1_addr, id_rs2_addr;
    logic          id_use_rs1, id_use_rs2;
    logic [XW-1:0] id_rs1_data, id_rs2_data;
    logic [4:0]    id_rd_addr;
    logic [XW-1:0] id_imm;
    logic [CW-1:0] id_ctrl;
    logic          id_mem_read;
    logic          wb_RegWEn;
    logic [4:0]    wb_rd_addr;
    logic [XW-1:0] wb_rd_data;
    logic          ex_stall, ex_flush;
    logic          stall_id;
    logic          ex_valid;
    logic [XW-1:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]    ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [CW-1:0] ex_ctrl;
    logic          ex_mem_read;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XW), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rd_addr(id_rd_addr), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .id_mem_read(id_mem_read),
        .wb_RegWEn(wb_RegWEn), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .ex_stall(ex_stall), .ex_flush(ex_flush),
        .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read)
    );

    task automatic clear_inputs();
        id_valid = 0; id_pc = '0; id_rs1_addr = '0; id_rs2_addr = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_rs1_data = '0; id_rs2_data = '0;
        id_rd_addr = '0; id_imm = '0; id_ctrl = '0; id_mem_read = 0;
        wb_RegWEn = 0; wb_rd_addr = '0; wb_rd_data = '0;
        ex_stall = 0; ex_flush = 0;
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [XW-1:0] pc, input logic [4:0] r1, input logic [XW-1:0] d1,
                           input logic [4:0] r2, input logic [XW-1:0] d2, input logic [4:0] rd,
                           input logic mr);
        id_valid = 1; id_pc = pc; id_rs1_addr = r1; id_rs1_data = d1;
        id_rs2_addr = r2; id_rs2_data = d2; id_rd_addr = rd; id_mem_read = mr;
        id_use_rs1 = 1; id_use_rs2 = 1; id_imm = pc + 32'h10; id_ctrl = pc[15:0] ^ 16'h5A5A;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick();
        n_checks++;
        if ({ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr,
             ex_rd_addr, ex_ctrl, ex_mem_read} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b pc=%h rs1=%h rs2=%h ctrl=%h mr=%b, expected all 0",
                     ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_ctrl, ex_mem_read);
        end
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall_id: got %b expected 0", stall_id);
        end
        rst = 0;
    endtask

    task automatic test_normal_flow();
        clear_inputs();
        present(32'h100, 5'd5, 32'hA, 5'd6, 32'hB, 5'd1, 1'b0);
        #2;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_stall_id: got %b expected 0", stall_id);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_rs1_data !== 32'hA ||
            ex_rs2_data !== 32'hB || ex_rd_addr !== 5'd1 || ex_rs1_addr !== 5'd5 ||
            ex_imm !== 32'h110 || ex_ctrl !== (16'h0100 ^ 16'h5A5A)) begin
            n_fail++;
            $display("FAIL normal_capture: got v=%b pc=%h rs1=%h rs2=%h rd=%0d imm=%h ctrl=%h expected v=1 pc=100 rs1=a rs2=b rd=1 imm=110 ctrl=%h",
                     ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_rd_addr, ex_imm, ex_ctrl,
                     16'h0100 ^ 16'h5A5A);
        end
    endtask

    task automatic test_bypass();
        clear_inputs();
        present(32'h104, 5'd7, 32'h11, 5'd7, 32'h22, 5'd2, 1'b0);
        wb_RegWEn = 1; wb_rd_addr = 5'd7; wb_rd_data = 32'h99;
        tick();
        n_checks++;
        if (ex_rs1_data !== 32'h99 || ex_rs2_data !== 32'h99) begin
            n_fail++;
            $display("FAIL bypass_hit: got rs1=%h rs2=%h expected 99/99", ex_rs1_data, ex_rs2_data);
        end
        wb_rd_addr = 5'd0;
        tick();
        n_checks++;
        if (ex_rs1_data !== 32'h11 || ex_rs2_data !== 32'h22) begin
            n_fail++;
            $display("FAIL bypass_wb_x0: got rs1=%h rs2=%h expected 11/22", ex_rs1_data, ex_rs2_data);
        end
        // Reading x0 while WB targets x0 must still yield the register-file value.
        id_rs1_addr = 5'd0; id_rs1_data = 32'h0;
        wb_rd_data = 32'hDEAD;
        tick();
        n_checks++;
        if (ex_rs1_data !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_x0_read: got %h expected 0", ex_rs1_data);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        present(32'h1F0, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 1'b1);
        tick();
        present(32'h200, 5'd4, 32'h44, 5'd3, 32'h33, 5'd8, 1'b0);
        id_use_rs1 = 0;
        #2;
        n_checks++;
        if (stall_id !== 1'b1) begin
            n_fail++;
            $display("FAIL loaduse_stall: got %b expected 1", stall_id);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || stall_id !== 1'b0) begin
            n_fail++;
            $display("FAIL loaduse_bubble: got v=%b mr=%b stall=%b expected 0/0/0",
                     ex_valid, ex_mem_read, stall_id);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_rs2_data !== 32'h33) begin
            n_fail++;
            $display("FAIL loaduse_replay: got v=%b pc=%h rs2=%h expected 1/200/33",
                     ex_valid, ex_pc, ex_rs2_data);
        end
        present(32'h204, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 1'b1);
        tick();
        present(32'h208, 5'd4, 32'h44, 5'd3, 32'h33, 5'd8, 1'b0);
        id_use_rs2 = 0;
        #2;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_fail++;
            $display("FAIL loaduse_unused_rs2: got stall %b expected 0", stall_id);
        end
        // A load targeting x0 never creates a hazard.
        present(32'h20C, 5'd1, 32'h1, 5'd2, 32'h2, 5'd0, 1'b1);
        tick();
        present(32'h210, 5'd0, 32'h0, 5'd0, 32'h0, 5'd8, 1'b0);
        #2;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_fail++;
            $display("FAIL loaduse_x0: got stall %b expected 0", stall_id);
        end
        tick();
    endtask

    task automatic test_hold_refresh();
        logic ok = 1'b1;
        clear_inputs();
        present(32'h300, 5'd9, 32'h33, 5'd10, 32'h44, 5'd11, 1'b0);
        tick();
        ex_stall = 1;
        present(32'h400, 5'd12, 32'h77, 5'd13, 32'h88, 5'd14, 1'b0);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                wb_RegWEn = 1; wb_rd_addr = 5'd9; wb_rd_data = 32'h55;
            end else begin
                wb_RegWEn = 0;
            end
            #2;
            if (stall_id !== 1'b1) ok = 1'b0;
            tick();
        end
        wb_RegWEn = 0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL hold_stall_id: stall_id dropped during ex_stall, expected 1 throughout");
        end
        ex_stall = 0;
        n_checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h300 || ex_rs1_data !== 32'h55 ||
            ex_rs2_data !== 32'h44 || ex_rd_addr !== 5'd11) begin
            n_fail++;
            $display("FAIL hold_refresh: got v=%b pc=%h rs1=%h rs2=%h rd=%0d expected 1/300/55/44/11",
                     ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_rd_addr);
        end
    endtask

    task automatic test_flush_priority();
        clear_inputs();
        present(32'h500, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 1'b1);
        tick();
        present(32'h504, 5'd3, 32'h3, 5'd3, 32'h3, 5'd4, 1'b1);
        ex_stall = 1; ex_flush = 1;
        #2;
        n_checks++;
        if (stall_id !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall_id: got %b expected 0", stall_id);
        end
        tick();
        n_checks++;
        if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_kill: got v=%b mr=%b expected 0/0", ex_valid, ex_mem_read);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        present(32'h600, 5'd5, 32'h5, 5'd6, 32'h6, 5'd7, 1'b1);
        tick();
        ex_stall = 1;
        tick();
        rst = 1;
        tick();
        rst = 0;
        n_checks++;
        if ({ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr,
             ex_rd_addr, ex_ctrl, ex_mem_read} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got v=%b pc=%h rs1=%h mr=%b expected all 0",
                     ex_valid, ex_pc, ex_rs1_data, ex_mem_read);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        logic          m_v, m_mr;
        logic [XW-1:0] m_pc, m_imm, m_d1, m_d2;
        logic [4:0]    m_a1, m_a2, m_rd;
        logic [CW-1:0] m_ctrl;
        logic          hz, exp_stall;
        int unsigned   bad_stall = 0, bad_state = 0;
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
        {m_v, m_mr, m_pc, m_imm, m_d1, m_d2, m_a1, m_a2, m_rd, m_ctrl} = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            id_valid    = ($urandom_range(0, 4) != 0);
            id_pc       = $urandom;
            id_imm      = $urandom;
            id_ctrl     = 16'($urandom);
            id_rs1_addr = 5'($urandom_range(0, 7));
            id_rs2_addr = 5'($urandom_range(0, 7));
            id_rd_addr  = 5'($urandom_range(0, 7));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            id_rs1_data = $urandom;
            id_rs2_data = $urandom;
            id_mem_read = ($urandom_range(0, 2) == 0);
            wb_RegWEn   = 1'($urandom_range(0, 1));
            wb_rd_addr  = 5'($urandom_range(0, 7));
            wb_rd_data  = $urandom;
            ex_stall    = ($urandom_range(0, 3) == 0);
            ex_flush    = ($urandom_range(0, 9) == 0);
            #2;
            hz = m_v && m_mr && m_rd != 0 && id_valid &&
                 ((id_use_rs1 && id_rs1_addr == m_rd) || (id_use_rs2 && id_rs2_addr == m_rd));
            exp_stall = !ex_flush && (ex_stall || hz);
            n_checks++;
            if (stall_id !== exp_stall) begin
                n_fail++;
                bad_stall++;
                if (bad_stall <= 5)
                    $display("FAIL rand_stall_id cyc %0d: got %b expected %b", cyc, stall_id, exp_stall);
            end
            if (ex_flush) begin
                m_v = 0; m_mr = 0;
            end else if (ex_stall) begin
                if (m_v && wb_RegWEn && wb_rd_addr != 0) begin
                    if (wb_rd_addr == m_a1) m_d1 = wb_rd_data;
                    if (wb_rd_addr == m_a2) m_d2 = wb_rd_data;
                end
            end else if (hz) begin
                m_v = 0; m_mr = 0;
            end else begin
                m_v = id_valid; m_mr = id_valid && id_mem_read;
                m_pc = id_pc; m_imm = id_imm; m_ctrl = id_ctrl;
                m_a1 = id_rs1_addr; m_a2 = id_rs2_addr; m_rd = id_rd_addr;
                m_d1 = (wb_RegWEn && wb_rd_addr != 0 && wb_rd_addr == id_rs1_addr) ? wb_rd_data : id_rs1_data;
                m_d2 = (wb_RegWEn && wb_rd_addr != 0 && wb_rd_addr == id_rs2_addr) ? wb_rd_data : id_rs2_data;
            end
            tick();
            n_checks++;
            if (ex_valid !== m_v || ex_mem_read !== m_mr ||
                (m_v && {ex_pc, ex_imm, ex_rs1_data, ex_rs2_data, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_ctrl}
                        !== {m_pc, m_imm, m_d1, m_d2, m_a1, m_a2, m_rd, m_ctrl})) begin
                n_fail++;
                bad_state++;
                if (bad_state <= 5)
                    $display("FAIL rand_state cyc %0d: got v=%b mr=%b pc=%h rs1=%h rs2=%h rd=%0d expected v=%b mr=%b pc=%h rs1=%h rs2=%h rd=%0d",
                             cyc, ex_valid, ex_mem_read, ex_pc, ex_rs1_data, ex_rs2_data, ex_rd_addr,
                             m_v, m_mr, m_pc, m_d1, m_d2, m_rd);
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_normal_flow();
        test_bypass();
        test_load_use();
        test_hold_refresh();
        test_flush_priority();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
